// File: rtl/hazard_if.sv
// Hazard interface between the pipelined datapath (master) and the hazard unit (slave).
// Carries register specifiers and write-enables in, stall/flush/forward controls and counters out.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic [4:0]       rsE;
  logic [4:0]       rtE;
  logic [4:0]       writeregE;
  logic [4:0]       writeregM;
  logic [4:0]       writeregW;
  logic             branchD;
  logic             MemtoRegE;
  logic             RegWriteE;
  logic             MemToRegM;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             mdStartE;
  logic             mdUseD;

  logic             stallF;
  logic             stallD;
  logic             flushE;
  logic             forwardAD;
  logic             forwardBD;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             mdBusy;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] mdStallCycles;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output branchD, MemtoRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW,
    output mdStartE, mdUseD,
    input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
    input  mdBusy, stallCycles, mdStallCycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  branchD, MemtoRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW,
    input  mdStartE, mdUseD,
    output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
    output mdBusy, stallCycles, mdStallCycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding controller for the five-stage MIPS pipeline, with a
// HI/LO busy counter for multi-cycle mult/div and saturating stall performance counters.
module hazard_unit #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  localparam logic [3:0]       MdLat  = 4'(MD_LAT);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [3:0]       mdCnt_q, mdCnt_d;
  logic [CNT_W-1:0] stallCycles_q, stallCycles_d;
  logic [CNT_W-1:0] mdStallCycles_q, mdStallCycles_d;

  logic       lwStall;
  logic       branchStall;
  logic       mdStall;
  logic       stall;
  logic [1:0] fwdAE;
  logic [1:0] fwdBE;
  logic       fwdAD;
  logic       fwdBD;

  // The M-stage result is newer than W, so it wins when both match; $0 never forwards.
  function automatic logic [1:0] selectE(input logic [4:0] src,
                                         input logic [4:0] wM, input logic wenM,
                                         input logic [4:0] wW, input logic wenW);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0 && src == wM && wenM) begin
      sel = 2'b10;
    end else if (src != 5'd0 && src == wW && wenW) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Everything combinational is held at zero while reset is asserted.
  always_comb begin
    lwStall     = 1'b0;
    branchStall = 1'b0;
    mdStall     = 1'b0;
    stall       = 1'b0;
    fwdAE       = 2'b00;
    fwdBE       = 2'b00;
    fwdAD       = 1'b0;
    fwdBD       = 1'b0;
    if (!rst) begin
      fwdAE = selectE(hz.rsE, hz.writeregM, hz.RegWriteM, hz.writeregW, hz.RegWriteW);
      fwdBE = selectE(hz.rtE, hz.writeregM, hz.RegWriteM, hz.writeregW, hz.RegWriteW);
      fwdAD = (hz.rsD != 5'd0) && (hz.rsD == hz.writeregM) && hz.RegWriteM;
      fwdBD = (hz.rtD != 5'd0) && (hz.rtD == hz.writeregM) && hz.RegWriteM;

      lwStall = hz.MemtoRegE && ((hz.rsD == hz.rtE) || (hz.rtD == hz.rtE));
      branchStall = hz.branchD &&
                    ((hz.RegWriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                     (hz.MemToRegM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
      mdStall = hz.mdUseD && (hz.mdStartE || (mdCnt_q != 4'd0));
      stall   = lwStall || branchStall || mdStall;
    end
  end

  // A start in E is real even when the same cycle flushes the bubble behind it.
  always_comb begin
    mdCnt_d         = mdCnt_q;
    stallCycles_d   = stallCycles_q;
    mdStallCycles_d = mdStallCycles_q;
    if (hz.mdStartE) begin
      mdCnt_d = MdLat;
    end else if (mdCnt_q != 4'd0) begin
      mdCnt_d = mdCnt_q - 4'd1;
    end
    if (stall && stallCycles_q != CntMax) begin
      stallCycles_d = stallCycles_q + CntOne;
    end
    if (mdStall && mdStallCycles_q != CntMax) begin
      mdStallCycles_d = mdStallCycles_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdCnt_q         <= 4'd0;
      stallCycles_q   <= '0;
      mdStallCycles_q <= '0;
    end else begin
      mdCnt_q         <= mdCnt_d;
      stallCycles_q   <= stallCycles_d;
      mdStallCycles_q <= mdStallCycles_d;
    end
  end

  assign hz.stallF        = stall;
  assign hz.stallD        = stall;
  assign hz.flushE        = stall;
  assign hz.forwardAE     = fwdAE;
  assign hz.forwardBE     = fwdBE;
  assign hz.forwardAD     = fwdAD;
  assign hz.forwardBD     = fwdBD;
  assign hz.mdBusy        = (mdCnt_q != 4'd0);
  assign hz.stallCycles   = stallCycles_q;
  assign hz.mdStallCycles = mdStallCycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a reference model pushes expected outputs to a
// scoreboard each cycle, popped and compared at the falling edge; directed checks cover the key scenarios.
module tb_hazard_unit;

  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct {
    logic       stall;
    logic [1:0] fAE;
    logic [1:0] fBE;
    logic       fAD;
    logic       fBD;
    logic       busy;
    int         stallCyc;
    int         mdCyc;
  } exp_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   mCnt;
  int   mStallCyc;
  int   mMdCyc;
  exp_t scoreboard[$];

  hazard_if #(.CNT_W(CNT_W)) hz ();

  hazard_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] refSelE(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (hz.RegWriteM && src == hz.writeregM) return 2'b10;
    if (hz.RegWriteW && src == hz.writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic refMdStall();
    return hz.mdUseD && (hz.mdStartE || mCnt != 0);
  endfunction

  function automatic logic refStall();
    logic lw, br;
    lw = hz.MemtoRegE && (hz.rsD == hz.rtE || hz.rtD == hz.rtE);
    br = hz.branchD &&
         ((hz.RegWriteE && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
          (hz.MemToRegM && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
    return lw || br || refMdStall();
  endfunction

  task automatic clearInputs();
    hz.rsD = 5'd0; hz.rtD = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
    hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
    hz.branchD = 1'b0; hz.MemtoRegE = 1'b0; hz.RegWriteE = 1'b0;
    hz.MemToRegM = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.mdStartE = 1'b0; hz.mdUseD = 1'b0;
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next one.
  task automatic applyStimulus();
    exp_t e;
    exp_t g;
    logic st;
    logic ms;
    st = refStall();
    ms = refMdStall();
    e.stall    = st;
    e.fAE      = refSelE(hz.rsE);
    e.fBE      = refSelE(hz.rtE);
    e.fAD      = (hz.rsD != 5'd0) && hz.RegWriteM && (hz.rsD == hz.writeregM);
    e.fBD      = (hz.rtD != 5'd0) && hz.RegWriteM && (hz.rtD == hz.writeregM);
    e.busy     = (mCnt != 0);
    e.stallCyc = mStallCyc;
    e.mdCyc    = mMdCyc;
    scoreboard.push_back(e);
    @(negedge clk);
    g = scoreboard.pop_front();
    checkOutput("sb_stallF", 32'(hz.stallF), 32'(g.stall));
    checkOutput("sb_stallD", 32'(hz.stallD), 32'(g.stall));
    checkOutput("sb_flushE", 32'(hz.flushE), 32'(g.stall));
    checkOutput("sb_forwardAE", 32'(hz.forwardAE), 32'(g.fAE));
    checkOutput("sb_forwardBE", 32'(hz.forwardBE), 32'(g.fBE));
    checkOutput("sb_forwardAD", 32'(hz.forwardAD), 32'(g.fAD));
    checkOutput("sb_forwardBD", 32'(hz.forwardBD), 32'(g.fBD));
    checkOutput("sb_mdBusy", 32'(hz.mdBusy), 32'(g.busy));
    checkOutput("sb_stallCycles", 32'(hz.stallCycles), 32'(g.stallCyc));
    checkOutput("sb_mdStallCycles", 32'(hz.mdStallCycles), 32'(g.mdCyc));
    @(posedge clk);
    if (hz.mdStartE) mCnt = MD_LAT;
    else if (mCnt != 0) mCnt = mCnt - 1;
    if (st && mStallCyc < CNT_MAX) mStallCyc++;
    if (ms && mMdCyc < CNT_MAX) mMdCyc++;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stallD"}, 32'(hz.stallD), 32'd0);
    checkOutput({tag, "_flushE"}, 32'(hz.flushE), 32'd0);
    checkOutput({tag, "_forwardAE"}, 32'(hz.forwardAE), 32'd0);
    checkOutput({tag, "_forwardAD"}, 32'(hz.forwardAD), 32'd0);
    checkOutput({tag, "_mdBusy"}, 32'(hz.mdBusy), 32'd0);
    checkOutput({tag, "_stallCycles"}, 32'(hz.stallCycles), 32'd0);
    checkOutput({tag, "_mdStallCycles"}, 32'(hz.mdStallCycles), 32'd0);
  endtask

  initial begin
    testsRun = 0; testsFailed = 0;
    mCnt = 0; mStallCyc = 0; mMdCyc = 0;

    // Reset with hazardous inputs present: every output must still read zero.
    rst = 1'b1;
    clearInputs();
    hz.mdUseD = 1'b1; hz.mdStartE = 1'b1; hz.MemtoRegE = 1'b1;
    hz.rsD = 5'd8; hz.rtE = 5'd8; hz.rsE = 5'd5; hz.writeregM = 5'd5; hz.RegWriteM = 1'b1;
    #2;
    checkAllZero("rst_init");
    @(posedge clk); #2;
    checkAllZero("rst_edge");
    clearInputs();
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // ALU chain forwarding priority.
    clearInputs();
    hz.writeregM = 5'd5; hz.RegWriteM = 1'b1; hz.rsE = 5'd5;
    applyStimulus();
    checkOutput("alu_M", 32'(hz.forwardAE), 32'd2);
    hz.writeregW = 5'd5; hz.RegWriteW = 1'b1;
    applyStimulus();
    checkOutput("alu_Mprio", 32'(hz.forwardAE), 32'd2);
    hz.RegWriteM = 1'b0;
    applyStimulus();
    checkOutput("alu_W", 32'(hz.forwardAE), 32'd1);
    hz.RegWriteM = 1'b1; hz.rsE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
    applyStimulus();
    checkOutput("alu_r0", 32'(hz.forwardAE), 32'd0);
    hz.rtE = 5'd7; hz.writeregW = 5'd7; hz.writeregM = 5'd6;
    applyStimulus();
    checkOutput("alu_BE_W", 32'(hz.forwardBE), 32'd1);

    // Load-use stall for one cycle.
    clearInputs();
    hz.MemtoRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8;
    #1;
    checkOutput("lu_stallF", 32'(hz.stallF), 32'd1);
    checkOutput("lu_flushE", 32'(hz.flushE), 32'd1);
    checkOutput("lu_cnt0", 32'(hz.stallCycles), 32'd0);
    applyStimulus();
    checkOutput("lu_cnt1", 32'(hz.stallCycles), 32'd1);
    clearInputs();
    applyStimulus();

    // Branch depends on an E-stage ALU result, then gets it forwarded from M.
    clearInputs();
    hz.branchD = 1'b1; hz.RegWriteE = 1'b1; hz.writeregE = 5'd3; hz.rtD = 5'd3;
    #1;
    checkOutput("br_stall", 32'(hz.stallD), 32'd1);
    applyStimulus();
    hz.RegWriteE = 1'b0; hz.writeregE = 5'd0;
    hz.MemToRegM = 1'b0; hz.writeregM = 5'd3; hz.RegWriteM = 1'b1;
    #1;
    checkOutput("br_nostall", 32'(hz.stallD), 32'd0);
    checkOutput("br_fwdBD", 32'(hz.forwardBD), 32'd1);
    applyStimulus();
    hz.MemToRegM = 1'b1;
    applyStimulus();

    // Clear counters between edges so the mult/div counts start from zero.
    clearInputs();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    mCnt = 0; mStallCyc = 0; mMdCyc = 0;
    @(posedge clk); #1;

    // Mult/div: dependent D instruction stalls MD_LAT+1 cycles.
    hz.mdUseD = 1'b1; hz.mdStartE = 1'b1;
    applyStimulus();
    checkOutput("md_busy_start", 32'(hz.mdBusy), 32'd1);
    hz.mdStartE = 1'b0;
    for (int i = 0; i < MD_LAT; i++) begin
      #1;
      checkOutput("md_window_stall", 32'(hz.stallD), 32'd1);
      applyStimulus();
    end
    #1;
    checkOutput("md_release", 32'(hz.stallD), 32'd0);
    checkOutput("md_busy_end", 32'(hz.mdBusy), 32'd0);
    checkOutput("md_stallCnt", 32'(hz.mdStallCycles), 32'd5);
    applyStimulus();

    // Restart while counting reloads the full latency.
    clearInputs();
    hz.mdStartE = 1'b1;
    applyStimulus();
    hz.mdStartE = 1'b0;
    applyStimulus();
    applyStimulus();
    hz.mdStartE = 1'b1;
    applyStimulus();
    hz.mdStartE = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("md_reload_busy", 32'(hz.mdBusy), 32'd1);
    applyStimulus();
    checkOutput("md_reload_done", 32'(hz.mdBusy), 32'd0);

    // Asynchronous reset mid-multiply.
    clearInputs();
    hz.mdStartE = 1'b1; hz.mdUseD = 1'b1;
    applyStimulus();
    hz.mdStartE = 1'b0;
    hz.MemtoRegE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
    hz.rsE = 5'd4; hz.writeregM = 5'd4; hz.RegWriteM = 1'b1; hz.rsD = 5'd4; hz.rtD = 5'd9;
    applyStimulus();
    checkOutput("rstmid_busy_before", 32'(hz.mdBusy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("rstmid");
    @(posedge clk); #2;
    checkAllZero("rstmid_hold");
    clearInputs();
    #1 rst = 1'b0;
    mCnt = 0; mStallCyc = 0; mMdCyc = 0;
    @(posedge clk); #1;
    applyStimulus();

    // Saturation of the stall counter.
    hz.MemtoRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8;
    repeat (20) applyStimulus();
    checkOutput("sat_stallCnt", 32'(hz.stallCycles), 32'd15);
    applyStimulus();
    checkOutput("sat_hold", 32'(hz.stallCycles), 32'd15);
    checkOutput("sat_mdCnt", 32'(hz.mdStallCycles), 32'd0);

    // Load-use and mult/div together count once in each counter.
    clearInputs();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    mCnt = 0; mStallCyc = 0; mMdCyc = 0;
    @(posedge clk); #1;
    hz.MemtoRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8; hz.mdUseD = 1'b1; hz.mdStartE = 1'b1;
    applyStimulus();
    checkOutput("both_stallCnt", 32'(hz.stallCycles), 32'd1);
    checkOutput("both_mdCnt", 32'(hz.mdStallCycles), 32'd1);
    clearInputs();
    repeat (5) applyStimulus();

    checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and forwarding controller for the five-stage pipelined MIPS core; the decision-making end of the hazard interface that the `datapath` module consumes. Watches register specifiers and write-enables from D, E, M and W. Drives the stall, flush and forwarding selects back into the datapath. Adds a busy counter for the multi-cycle multiply/divide (HI/LO) unit and saturating performance counters for stall cycles.

## Interface
- `MD_LAT`, default 4: multiply/divide latency in cycles; legal range 1..15.
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rsD`, `rtD`  in  5 each  source registers of the instruction in D.
- `rsE`, `rtE`  in  5 each  source registers of the instruction in E.
- `writeregE`, `writeregM`, `writeregW`  in  5 each  destination registers in E, M and W.
- `branchD`  in  1  D holds a beq/bne.
- `MemtoRegE`, `RegWriteE`  in  1 each  E-stage load flag and write-enable.
- `MemToRegM`, `RegWriteM`  in  1 each  M-stage load flag and write-enable.
- `RegWriteW`  in  1  W-stage write-enable.
- `mdStartE`  in  1  one-cycle pulse: a mult/div is in E.
- `mdUseD`  in  1  D holds mfhi/mflo/mult/div (needs HI/LO free).
- `stallF`, `stallD`  out  1 each  hold PC and the IF/ID register.
- `flushE`  out  1  clear the ID/EX register.
- `forwardAD`, `forwardBD`  out  1 each  forward ALUOutM into the D-stage comparator.
- `forwardAE`, `forwardBE`  out  2 each  E-stage ALU operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
- `mdBusy`  out  1  HI/LO unit busy (`mdCnt != 0`).
- `stallCycles`  out  CNT_W  count of cycles with `stallD` = 1.
- `mdStallCycles`  out  CNT_W  count of cycles stalled by `mdstall`.

## Operation
- **Register 0:** a specifier of 0 never matches for forwarding.
- **E-stage forwarding:**
  - `forwardAE` = 10 if `rsE`≠0 && `rsE`==`writeregM` && `RegWriteM`.
  - Otherwise 01 if `rsE`≠0 && `rsE`==`writeregW` && `RegWriteW`.
  - Otherwise 00.
  - `forwardBE` uses the same rule with `rtE`. The M match has priority over W.
- **D-stage forwarding:**
  - `forwardAD` = `rsD`≠0 && `rsD`==`writeregM` && `RegWriteM`.
  - `forwardBD` uses the same rule with `rtD`.
- **lwstall** = `MemtoRegE` && (`rsD`==`rtE` || `rtD`==`rtE`).
- **branchstall** = `branchD` && ( (`RegWriteE` && `writeregE`∈{`rsD`,`rtD`}) || (`MemToRegM` && `writeregM`∈{`rsD`,`rtD`}) ).
- **mdstall** = `mdUseD` && (`mdStartE` || `mdCnt`≠0).
- **stall** = lwstall | branchstall | mdstall. `stallF` = `stallD` = `flushE` = stall.
- **HI/LO counter** (`mdCnt`, 4 bits):
  - On `mdStartE`: `mdCnt` <= `MD_LAT`. A restart while already nonzero reloads `MD_LAT`.
  - Otherwise, if nonzero: `mdCnt` <= `mdCnt`−1.
  - Otherwise: hold.
- **Performance counters:**
  - `stallCycles` increments on every rising edge where stall = 1.
  - `mdStallCycles` increments only where mdstall = 1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- **Reset:**
  - While `rst` = 1, all combinational outputs are forced to 0.
  - `mdCnt` = 0, `mdBusy` = 0, both counters = 0.
  - Asserting reset mid-multiply abandons the operation immediately.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs, valid within the same cycle. Zero latency.
- `mdCnt`, `mdBusy` and the counters are registered. They update on the rising edge and reset asynchronously.
- Multiply/divide stall window: with a `mdStartE` pulse in cycle t, a dependent D instruction stalls in cycles t..t+MD_LAT, i.e. MD_LAT+1 cycles. It proceeds in cycle t+MD_LAT+1.
- Simultaneous lwstall and mdstall in one cycle: `stallCycles` +1 and `mdStallCycles` +1. Counters never double-count a cycle.
- `flushE` with `mdStartE` in the same cycle: the start is honoured (the instruction in E is real). Only the bubble behind it is flushed.

## Test plan
- **ALU chain:**
  - `writeregM`=5, `RegWriteM`=1, `rsE`=5 -> `forwardAE`=10.
  - Also `writeregW`=5, `RegWriteW`=1 -> still 10 (M priority).
  - Drop `RegWriteM` -> 01.
  - `rsE`=0 with all matches -> 00.
- **Load-use:** `MemtoRegE`=1, `rtE`=8, `rsD`=8 for one cycle -> `stallF`=`stallD`=`flushE`=1; `stallCycles` goes 0 -> 1 at the next edge.
- **Branch hazards:**
  - `branchD`=1, `RegWriteE`=1, `writeregE`=3, `rtD`=3 -> stall=1.
  - Next cycle (`MemToRegM`=0, `writeregM`=3, `RegWriteM`=1) -> stall=0, `forwardBD`=1.
- **Multiply/divide (MD_LAT=4):**
  - `mdStartE` pulse in cycle t, `mdUseD` held 1 -> stall=1 for exactly 5 cycles; `mdCnt` sequence 4,3,2,1,0; `mdStallCycles`=5.
  - Second `mdStartE` at `mdCnt`=2 -> reloads to 4.
- **Reset mid-operation:** assert `rst` asynchronously (between edges) at `mdCnt`=3 -> `mdCnt`, `mdBusy` and counters are 0 immediately; all outputs are 0 while `rst`=1.
- **Saturation (CNT_W=4):** hold lwstall for 20 cycles -> `stallCycles` reaches 15 and stays at 15.
